text_writer: RTL

Write-side companion to the glyph renderer. Consumes a byte stream of ASCII characters and control codes over a valid/ready handshake, and maintains a text cursor. Issues single-cycle writes of 7-bit character codes into the character tile RAM that the renderer reads through the ASCII ROM. The default grid is 80×30 cells of 8×16 glyphs, covering 640×480. The block handles cursor advance, line wrap, carriage return, line feed, backspace and a full-screen clear.

---
 rtl/text_writer_if.sv | 27 ++
 rtl/text_writer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/text_writer_if.sv
// text_writer_if: byte-stream input and tile-RAM write bus of the text writer.
//   in_valid/in_char/in_ready : valid/ready byte stream (producer -> writer)
//   wr_en/wr_addr/wr_data     : single-cycle tile RAM write strobe, address, code
//   cursor_x/cursor_y         : current text cursor
//   busy                      : screen clear in progress
// Modports: master = byte producer / RAM side, slave = the writer itself.
interface text_writer_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    modport master (
        output in_valid, in_char,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
    );

    modport slave (
        input  in_valid, in_char,
        output in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_writer.sv
// text_writer: consumes ASCII bytes and control codes, maintains a text cursor
// and issues single-cycle writes of 7-bit character codes into the tile RAM.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; starts a full-screen clear
//   bus   : text_writer_if.slave (byte stream in, tile RAM writes and cursor out)
// Handles printable advance with wrap, CR, LF, BS and FF (full-screen clear).
module text_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic          clk,
    input  logic          reset,
    text_writer_if.slave  bus
);

    localparam int          N      = COLS * ROWS;
    localparam logic [11:0] LAST   = 12'(N - 1);
    localparam logic [6:0]  X_MAX  = 7'(COLS - 1);
    localparam logic [4:0]  Y_MAX  = 5'(ROWS - 1);
    localparam logic [11:0] COLS12 = 12'(COLS);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [6:0]  wr_data_q, wr_data_d;

    logic        idle;
    logic        accept;
    logic [11:0] cur_addr;
    logic [4:0]  y_next;
    logic [7:0]  c;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && bus.in_valid;
    assign c      = bus.in_char;

    // Constant multiply folds to shift-add (row*64 + row*16 for 80 columns).
    assign cur_addr = 12'(cur_y_q) * COLS12 + 12'(cur_x_q);
    // Row advance never scrolls: the last row wraps back to the top.
    assign y_next   = (cur_y_q == Y_MAX) ? 5'd0 : cur_y_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = 7'h00;
                if (clr_cnt_q == LAST) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = 12'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (c >= 8'h20 && c <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = c[6:0];
                        if (cur_x_q == X_MAX) begin
                            cur_x_d = 7'd0;
                            cur_y_d = y_next;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else if (c == 8'h0D) begin
                        cur_x_d = 7'd0;
                    end else if (c == 8'h0A) begin
                        cur_x_d = 7'd0;
                        cur_y_d = y_next;
                    end else if (c == 8'h08) begin
                        // Blank the cell we step back onto; same row, so addr-1.
                        if (cur_x_q != 7'd0) begin
                            cur_x_d   = cur_x_q - 7'd1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cur_addr - 12'd1;
                            wr_data_d = 7'h00;
                        end
                    end else if (c == 8'h0C) begin
                        cur_x_d   = 7'd0;
                        cur_y_d   = 5'd0;
                        clr_cnt_d = 12'd0;
                        state_d   = S_CLEAR;
                    end
                    // anything else is consumed without effect
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 12'd0;
            cur_x_q   <= 7'd0;
            cur_y_q   <= 5'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 12'd0;
            wr_data_q <= 7'h00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready = idle;
    assign bus.busy     = ~idle;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cursor_x = cur_x_q;
    assign bus.cursor_y = cur_y_q;

endmodule
